// File: rtl/ex_hazard_ctrl.sv
// Pipeline control for the five-stage core: load-use stall detection, redirect flushes,
// halt/resume sequencing on a syscall in EX, and free-running performance counters.
module ex_hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             go,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_dst,
  input  logic             ex_jb,
  input  logic             ex_halt,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             pipe_en,
  output logic             lu,
  output logic             halted,
  output logic [CNT_W-1:0] cnt_cycle,
  output logic [CNT_W-1:0] cnt_jb,
  output logic [CNT_W-1:0] cnt_lu
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HALT   = 2'd1,
    ST_RESUME = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  state_t           state_q, state_d;
  logic             lu_q, lu_d;
  logic             halted_q, halted_d;
  logic [CNT_W-1:0] cnt_cycle_q, cnt_cycle_d;
  logic [CNT_W-1:0] cnt_jb_q, cnt_jb_d;
  logic [CNT_W-1:0] cnt_lu_q, cnt_lu_d;
  logic             hz;
  logic             hlt;
  logic             active;

  // Load-use hazard: EX load writes a non-zero register that ID is about to read
  always_comb begin
    hz = ex_mem_read && (ex_dst != 5'd0) &&
         ((id_use_rs && (id_rs == ex_dst)) || (id_use_rt && (id_rt == ex_dst)));
  end

  // Next-state and enable/flush decode; RESUME masks the frozen syscall
  always_comb begin
    state_d    = state_q;
    hlt        = 1'b0;
    pc_en      = 1'b0;
    ifid_en    = 1'b0;
    pipe_en    = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    case (state_q)
      ST_RUN, ST_RESUME: begin
        hlt = (state_q == ST_RUN) && ex_halt;
        if (hlt) begin
          state_d = ST_HALT;
        end else if (ex_jb) begin
          state_d    = ST_RUN;
          pc_en      = 1'b1;
          ifid_en    = 1'b1;
          pipe_en    = 1'b1;
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end else if (hz) begin
          state_d    = ST_RUN;
          pipe_en    = 1'b1;
          idex_flush = 1'b1;
        end else begin
          state_d = ST_RUN;
          pc_en   = 1'b1;
          ifid_en = 1'b1;
          pipe_en = 1'b1;
        end
      end
      ST_HALT: begin
        if (go) begin
          state_d = ST_RESUME;
        end else begin
          state_d = ST_HALT;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // Marker, status and counter next values; everything freezes while halted
  always_comb begin
    active      = (state_q != ST_HALT);
    halted_d    = (state_d == ST_HALT);
    lu_d        = lu_q;
    cnt_cycle_d = cnt_cycle_q;
    cnt_jb_d    = cnt_jb_q;
    cnt_lu_d    = cnt_lu_q;
    if (active) begin
      lu_d        = hz && !ex_jb && !hlt;
      cnt_cycle_d = cnt_cycle_q + CNT_ONE;
      cnt_jb_d    = (ex_jb && !hlt) ? (cnt_jb_q + CNT_ONE) : cnt_jb_q;
      cnt_lu_d    = (hz && !ex_jb && !hlt) ? (cnt_lu_q + CNT_ONE) : cnt_lu_q;
    end else begin
      lu_d = lu_q;
    end
  end

  // State, marker and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      lu_q        <= 1'b0;
      halted_q    <= 1'b0;
      cnt_cycle_q <= CNT_ZERO;
      cnt_jb_q    <= CNT_ZERO;
      cnt_lu_q    <= CNT_ZERO;
    end else begin
      state_q     <= state_d;
      lu_q        <= lu_d;
      halted_q    <= halted_d;
      cnt_cycle_q <= cnt_cycle_d;
      cnt_jb_q    <= cnt_jb_d;
      cnt_lu_q    <= cnt_lu_d;
    end
  end

  assign lu        = lu_q;
  assign halted    = halted_q;
  assign cnt_cycle = cnt_cycle_q;
  assign cnt_jb    = cnt_jb_q;
  assign cnt_lu    = cnt_lu_q;

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Directed bench for ex_hazard_ctrl: vector table in RUN, then halt/resume,
// asynchronous reset during HALT, and 4-bit counter wrap on a second instance.
module tb_ex_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       go;
  logic [4:0] id_rs, id_rt, ex_dst;
  logic       id_use_rs, id_use_rt, ex_mem_read, ex_jb, ex_halt;

  logic        pc_en, ifid_en, ifid_flush, idex_flush, pipe_en, lu, halted;
  logic [31:0] cnt_cycle, cnt_jb, cnt_lu;
  logic        pc_en4, ifid_en4, ifid_flush4, idex_flush4, pipe_en4, lu4, halted4;
  logic [3:0]  cnt_cycle4, cnt_jb4, cnt_lu4;

  int errors = 0;
  int checks = 0;
  int exp_cycle = 0, exp_jb = 0, exp_lu = 0;

  always #5 clk = ~clk;

  ex_hazard_ctrl #(.CNT_W(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .go(go), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .ex_mem_read(ex_mem_read),
    .ex_dst(ex_dst), .ex_jb(ex_jb), .ex_halt(ex_halt), .pc_en(pc_en),
    .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .pipe_en(pipe_en), .lu(lu), .halted(halted), .cnt_cycle(cnt_cycle),
    .cnt_jb(cnt_jb), .cnt_lu(cnt_lu)
  );

  ex_hazard_ctrl #(.CNT_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .go(go), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .ex_mem_read(ex_mem_read),
    .ex_dst(ex_dst), .ex_jb(ex_jb), .ex_halt(ex_halt), .pc_en(pc_en4),
    .ifid_en(ifid_en4), .ifid_flush(ifid_flush4), .idex_flush(idex_flush4),
    .pipe_en(pipe_en4), .lu(lu4), .halted(halted4), .cnt_cycle(cnt_cycle4),
    .cnt_jb(cnt_jb4), .cnt_lu(cnt_lu4)
  );

  typedef struct packed {
    logic       go;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic       mr;
    logic [4:0] dst;
    logic       jb;
    logic       e_pc;
    logic       e_ifid;
    logic       e_iff;
    logic       e_idf;
    logic       e_pipe;
    logic       e_lu;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic g, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt, input logic mr,
                       input logic [4:0] dst, input logic jb, input logic hlt);
    go = g; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
    ex_mem_read = mr; ex_dst = dst; ex_jb = jb; ex_halt = hlt;
  endtask

  task automatic chk_ctrl(input string tag, input logic [4:0] e);
    chk({tag, ".pc_en"},      {31'd0, pc_en},      {31'd0, e[4]});
    chk({tag, ".ifid_en"},    {31'd0, ifid_en},    {31'd0, e[3]});
    chk({tag, ".ifid_flush"}, {31'd0, ifid_flush}, {31'd0, e[2]});
    chk({tag, ".idex_flush"}, {31'd0, idex_flush}, {31'd0, e[1]});
    chk({tag, ".pipe_en"},    {31'd0, pipe_en},    {31'd0, e[0]});
  endtask

  task automatic chk_cnt(input string tag);
    chk({tag, ".cnt_cycle"},  cnt_cycle, exp_cycle);
    chk({tag, ".cnt_jb"},     cnt_jb,    exp_jb);
    chk({tag, ".cnt_lu"},     cnt_lu,    exp_lu);
    chk({tag, ".cnt_cycle4"}, {28'd0, cnt_cycle4}, {28'd0, 4'(exp_cycle)});
  endtask

  initial begin
    //                  go    rs     rt     urs   urt   mr    dst    jb    pc ifid iff idf pipe lu
    vecs[0]  = '{1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b1,1'b1,1'b0,1'b0,1'b1,1'b0};
    vecs[1]  = '{1'b0, 5'd8,  5'd0,  1'b1, 1'b0, 1'b1, 5'd8,  1'b0, 1'b0,1'b0,1'b0,1'b1,1'b1,1'b1};
    vecs[2]  = '{1'b0, 5'd0,  5'd0,  1'b1, 1'b0, 1'b1, 5'd0,  1'b0, 1'b1,1'b1,1'b0,1'b0,1'b1,1'b0};
    vecs[3]  = '{1'b0, 5'd8,  5'd0,  1'b1, 1'b0, 1'b1, 5'd8,  1'b1, 1'b1,1'b1,1'b1,1'b1,1'b1,1'b0};
    vecs[4]  = '{1'b0, 5'd1,  5'd5,  1'b0, 1'b1, 1'b1, 5'd5,  1'b0, 1'b0,1'b0,1'b0,1'b1,1'b1,1'b1};
    vecs[5]  = '{1'b0, 5'd1,  5'd5,  1'b0, 1'b0, 1'b1, 5'd5,  1'b0, 1'b1,1'b1,1'b0,1'b0,1'b1,1'b0};
    vecs[6]  = '{1'b0, 5'd9,  5'd0,  1'b1, 1'b0, 1'b0, 5'd9,  1'b0, 1'b1,1'b1,1'b0,1'b0,1'b1,1'b0};
    vecs[7]  = '{1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  1'b1, 1'b1,1'b1,1'b1,1'b1,1'b1,1'b0};
    vecs[8]  = '{1'b0, 5'd3,  5'd7,  1'b1, 1'b1, 1'b1, 5'd7,  1'b0, 1'b0,1'b0,1'b0,1'b1,1'b1,1'b1};
    vecs[9]  = '{1'b0, 5'd31, 5'd2,  1'b1, 1'b0, 1'b1, 5'd31, 1'b0, 1'b0,1'b0,1'b0,1'b1,1'b1,1'b1};
    vecs[10] = '{1'b1, 5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b1,1'b1,1'b0,1'b0,1'b1,1'b0};

    rst_n = 1'b0;
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    #12;
    chk_ctrl("reset", 5'b11001);
    chk("reset.lu",     {31'd0, lu},     32'd0);
    chk("reset.halted", {31'd0, halted}, 32'd0);
    chk_cnt("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Idle run
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      exp_cycle++;
    end
    chk_ctrl("idle", 5'b11001);
    chk("idle.lu", {31'd0, lu}, 32'd0);
    chk_cnt("idle");

    // Table vectors, all in RUN
    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].go, vecs[i].rs, vecs[i].rt, vecs[i].urs, vecs[i].urt,
            vecs[i].mr, vecs[i].dst, vecs[i].jb, 1'b0);
      @(negedge clk);
      chk_ctrl($sformatf("vec%0d", i),
               {vecs[i].e_pc, vecs[i].e_ifid, vecs[i].e_iff, vecs[i].e_idf, vecs[i].e_pipe});
      @(posedge clk); #1;
      exp_cycle++;
      if (vecs[i].jb) exp_jb++;
      if (vecs[i].e_lu) exp_lu++;
      chk($sformatf("vec%0d.lu", i),     {31'd0, lu},     {31'd0, vecs[i].e_lu});
      chk($sformatf("vec%0d.halted", i), {31'd0, halted}, 32'd0);
      chk_cnt($sformatf("vec%0d", i));
    end

    // Halt held 10 cycles, go at cycle 6; hazard and redirect noise while halted
    for (int k = 0; k < 10; k++) begin
      if (k >= 2 && k <= 5)
        drive(k == 6, 5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 5'd8, 1'b1, 1'b1);
      else
        drive(k == 6, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
      @(negedge clk);
      chk_ctrl($sformatf("halt%0d", k), (k == 7) ? 5'b11001 : 5'b00000);
      chk($sformatf("halt%0d.halted", k), {31'd0, halted},
          {31'd0, ((k >= 1 && k <= 6) || k == 9)});
      @(posedge clk); #1;
      if (k == 0 || k == 7 || k == 8) exp_cycle++;
      chk($sformatf("halt%0d.lu", k), {31'd0, lu}, 32'd0);
      chk_cnt($sformatf("halt%0d", k));
    end

    // Asynchronous reset while halted
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    chk("prerst.halted", {31'd0, halted}, 32'd1);
    rst_n = 1'b0;
    #1;
    exp_cycle = 0; exp_jb = 0; exp_lu = 0;
    chk("arst.halted", {31'd0, halted}, 32'd0);
    chk("arst.lu",     {31'd0, lu},     32'd0);
    chk_ctrl("arst", 5'b11001);
    chk_cnt("arst");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 17 unhalted cycles: 4-bit counter wraps to 1
    for (int i = 0; i < 17; i++) begin
      @(posedge clk); #1;
      exp_cycle++;
    end
    chk("wrap.cnt_cycle4", {28'd0, cnt_cycle4}, 32'd1);
    chk("wrap.cnt_cycle",  cnt_cycle, 32'd17);
    chk_cnt("wrap");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
